// File: rtl/cpu_jtag_ocimem_ctrl_pkg.sv
// Shared types and constants for the OCI debug-memory controller.
package cpu_jtag_ocimem_ctrl_pkg;

  localparam int JDO_W          = 38;
  localparam int DATA_W         = 32;
  localparam int JDO_RD_BIT     = 35;
  localparam int JDO_CLRERR_BIT = 34;
  localparam int JDO_DATA_LSB   = 3;
  localparam int JDO_ADDR_LSB   = 2;
  localparam int OCI_RAM_DEPTH  = 256;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_JRD_WAIT    = 2'd1,
    ST_CPU_RD_WAIT = 2'd2
  } ocimem_state_e;

  function automatic logic [DATA_W-1:0] jdo_data(input logic [JDO_W-1:0] jdo);
    return jdo[JDO_DATA_LSB +: DATA_W];
  endfunction

endpackage

// File: rtl/cpu_jtag_ocimem_ctrl_if.sv
// CPU debug-slave bus into the OCI memory controller.
interface cpu_jtag_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  import cpu_jtag_ocimem_ctrl_pkg::*;

  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic              cpu_debugaccess;
  logic [DATA_W-1:0] cpu_readdata;
  logic              cpu_waitrequest;

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, cpu_debugaccess,
    input  cpu_readdata, cpu_waitrequest
  );

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, cpu_debugaccess,
    output cpu_readdata, cpu_waitrequest
  );

endinterface

// File: rtl/cpu_jtag_ocimem_pending.sv
// Single-entry slot for posted JTAG memory ops; flags posts it cannot accept.
module cpu_jtag_ocimem_pending (
  input  logic clk,
  input  logic reset_n,
  input  logic post_rd_i,
  input  logic post_wr_i,
  input  logic busy_i,
  input  logic take_i,
  output logic vld_o,
  output logic is_wr_o,
  output logic accept_o,
  output logic overrun_o
);

  logic vld_q;
  logic wr_q;
  logic post;

  assign post      = post_rd_i | post_wr_i;
  assign accept_o  = post & ~vld_q & ~busy_i;
  assign overrun_o = post & ~accept_o;
  assign vld_o     = vld_q;
  assign is_wr_o   = wr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      wr_q  <= 1'b0;
    end else if (accept_o) begin
      vld_q <= 1'b1;
      wr_q  <= post_wr_i;
    end else if (take_i) begin
      vld_q <= 1'b0;
      wr_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_jtag_ocimem_ctrl.sv
// OCI RAM arbiter between JTAG monitor ops and CPU debug-slave accesses.
// Optional: OCIMEM_DEBUGACCESS_EN blocks CPU accesses made outside debug mode.
module cpu_jtag_ocimem_ctrl
  import cpu_jtag_ocimem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [JDO_W-1:0]      jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic                  take_no_action_ocimem_a,
  cpu_jtag_ocimem_ctrl_if.slave cpu,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_wren,
  output logic [3:0]            ram_byteenable,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [DATA_W-1:0]     MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error
);

  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  ocimem_state_e     state_q;
  logic [1:0]        cnt_q;
  logic              rd_done_q;
  logic              cpu_dbg_q;
  logic [ADDR_W-1:0] mon_a_q;
  logic [DATA_W-1:0] mon_d_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              ready_q;
  logic              err_q;

  logic post_rd, post_wr, post_any;
  logic pend_vld, pend_wr, pend_accept, pend_overrun;
  logic jtag_take, jwr_fire, jrd_done, addr_inc, cnt_done;
  logic cpu_req, cpu_gnt, cpu_wr_gnt, cpu_rd_gnt, cpu_ack_rd;
  logic dbg_ok;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_ADDR_LSB-1:0]};

`ifdef OCIMEM_DEBUGACCESS_EN
  assign dbg_ok = cpu.cpu_debugaccess;
`else
  logic unused_dbg;
  assign unused_dbg = cpu.cpu_debugaccess;
  assign dbg_ok     = 1'b1;
`endif

  assign post_rd  = take_no_action_ocimem_a | (take_action_ocimem_a & jdo[JDO_RD_BIT]);
  assign post_wr  = take_action_ocimem_b;
  assign post_any = post_rd | post_wr;

  cpu_jtag_ocimem_pending u_pending (
    .clk       (clk),
    .reset_n   (reset_n),
    .post_rd_i (post_rd),
    .post_wr_i (post_wr),
    .busy_i    (state_q == ST_JRD_WAIT),
    .take_i    (jtag_take),
    .vld_o     (pend_vld),
    .is_wr_o   (pend_wr),
    .accept_o  (pend_accept),
    .overrun_o (pend_overrun)
  );

  // JTAG owns the RAM whenever an op is pending or arriving; the CPU waits.
  always_comb begin
    cnt_done   = (cnt_q == LAST_CNT);
    jtag_take  = (state_q == ST_IDLE) && pend_vld;
    jwr_fire   = jtag_take && pend_wr;
    jrd_done   = (state_q == ST_JRD_WAIT) && cnt_done;
    addr_inc   = jwr_fire || jrd_done;
    cpu_req    = cpu.cpu_read || cpu.cpu_write;
    cpu_ack_rd = (state_q == ST_IDLE) && rd_done_q && cpu.cpu_read;
    cpu_gnt    = (state_q == ST_IDLE) && !pend_vld && !post_any && !rd_done_q && cpu_req;
    cpu_wr_gnt = cpu_gnt && cpu.cpu_write;
    cpu_rd_gnt = cpu_gnt && !cpu.cpu_write;

    ram_addr       = mon_a_q;
    ram_wren       = 1'b0;
    ram_byteenable = 4'h0;
    ram_wdata      = mon_d_q;
    if (jwr_fire) begin
      ram_wren       = 1'b1;
      ram_byteenable = 4'hF;
    end else if (cpu_gnt || (state_q == ST_CPU_RD_WAIT)) begin
      ram_addr       = cpu.cpu_address;
      ram_byteenable = cpu.cpu_byteenable;
      ram_wdata      = cpu.cpu_writedata;
      ram_wren       = cpu_wr_gnt && dbg_ok;
    end
  end

  assign cpu.cpu_waitrequest = cpu_req && !(cpu_wr_gnt || cpu_ack_rd);
  assign cpu.cpu_readdata    = cpu_rdata_q;
  assign MonDReg             = mon_d_q;
  assign monitor_ready       = ready_q;
  assign monitor_error       = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      rd_done_q   <= 1'b0;
      cpu_dbg_q   <= 1'b0;
      mon_a_q     <= '0;
      mon_d_q     <= '0;
      cpu_rdata_q <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (pend_overrun) begin
        err_q <= 1'b1;
      end else if (take_action_ocimem_a && jdo[JDO_CLRERR_BIT]) begin
        err_q <= 1'b0;
      end

      if (addr_inc) begin
        ready_q <= 1'b1;
      end else if (pend_accept) begin
        ready_q <= 1'b0;
      end

      // A dropped read post must not disturb the address register.
      if (take_action_ocimem_a && (!jdo[JDO_RD_BIT] || pend_accept)) begin
        mon_a_q <= jdo[JDO_ADDR_LSB +: ADDR_W];
      end else if (addr_inc) begin
        mon_a_q <= mon_a_q + ADDR_W'(1);
      end

      if (take_action_ocimem_b && pend_accept) begin
        mon_d_q <= jdo_data(jdo);
      end else if (jrd_done) begin
        mon_d_q <= ram_rdata;
      end

      case (state_q)
        ST_IDLE: begin
          rd_done_q <= 1'b0;
          cnt_q     <= 2'd0;
          if (jtag_take && !pend_wr) begin
            state_q <= ST_JRD_WAIT;
          end else if (cpu_rd_gnt) begin
            state_q   <= ST_CPU_RD_WAIT;
            cpu_dbg_q <= dbg_ok;
          end
        end
        ST_JRD_WAIT: begin
          if (cnt_done) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        ST_CPU_RD_WAIT: begin
          if (cnt_done) begin
            cpu_rdata_q <= cpu_dbg_q ? ram_rdata : '0;
            rd_done_q   <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
